spi_master: RTL and testbench

//  Host-side SPI master for the SPI-slave/single-port-RAM subsystem. Takes one

---
 rtl/spi_master.sv | 211 +++++++++++++++++++++
 tb/tb_spi_master.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: host-side SPI master for the SPI-slave/RAM subsystem.
// Sends a 10-bit frame {op, data} MSB first under SS_n. For op 11 it then
// waits RD_LATENCY cycles and shifts in the 8-bit read byte from MISO.
// Optional feature macro: SPI_MASTER_RDADDR_CHECK_EN. When it is defined, an op-11
// command that has no earlier op-10 frame since reset is rejected locally with rsp_err.
module spi_master #(
  parameter int unsigned LEAD_CYCLES = 1,
  parameter int unsigned RD_LATENCY  = 2,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       done,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int unsigned FRAME_W = 10;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned MAX_LR  = (LEAD_CYCLES > RD_LATENCY) ? LEAD_CYCLES : RD_LATENCY;
  localparam int unsigned MAX_LRG = (MAX_LR > GAP_CYCLES) ? MAX_LR : GAP_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_LRG > FRAME_W) ? MAX_LRG : FRAME_W;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT_OUT,
    ST_WAIT_RD,
    ST_SHIFT_IN,
    ST_GAP,
    ST_REJECT
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  state_t              w_after_frame;
  state_t              w_after_out;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [FRAME_W-1:0]  r_frame;
  logic [FRAME_W-1:0]  w_frame_nxt;
  logic [BYTE_W-2:0]   r_sh;
  logic [BYTE_W-1:0]   r_rsp_data;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic                r_done;
  logic                r_ss_n;
  logic                r_mosi;
  logic                r_cmd_ready;
  logic                r_busy;
  logic                w_accept;
  logic                w_reject;
  logic                w_rd_blocked;
  logic                w_last;
  logic                w_capture;
  logic                w_frame_done;
  logic                w_ss_n_nxt;
  logic                w_mosi_nxt;
  logic                w_ready_nxt;
  logic [3:0]          w_bit_idx;

  // Last cycle of the current timed state.
  always_comb begin
    w_last = 1'b0;
    case (r_state)
      ST_LEAD:      w_last = (r_cnt == CNT_W'(LEAD_CYCLES - 1));
      ST_SHIFT_OUT: w_last = (r_cnt == CNT_W'(FRAME_W - 1));
      ST_WAIT_RD:   w_last = (r_cnt == CNT_W'(RD_LATENCY - 1));
      ST_SHIFT_IN:  w_last = (r_cnt == CNT_W'(BYTE_W - 1));
      ST_GAP:       w_last = (r_cnt == CNT_W'(GAP_CYCLES - 1));
      default:      w_last = 1'b0;
    endcase
  end

  assign w_capture = (r_state == ST_SHIFT_IN) && w_last;

`ifdef SPI_MASTER_RDADDR_CHECK_EN
  logic r_rdaddr_seen;

  // Remember that a read-address frame has completed since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdaddr_seen <= 1'b0;
    end else if (w_frame_done && (r_frame[FRAME_W-1 -: 2] == OP_RD_ADDR)) begin
      r_rdaddr_seen <= 1'b1;
    end
  end

  assign w_rd_blocked = (cmd_op == OP_RD_DATA) && !r_rdaddr_seen;
`else
  assign w_rd_blocked = 1'b0;
`endif

  // Next-state, counter and registered-output next values.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + CNT_W'(1);
    w_frame_nxt   = r_frame;
    w_accept      = cmd_valid & r_cmd_ready;
    w_reject      = 1'b0;
    w_after_frame = (GAP_CYCLES != 0) ? ST_GAP : ST_IDLE;
    w_after_out   = w_after_frame;
    if (r_frame[FRAME_W-1 -: 2] == OP_RD_DATA) begin
      w_after_out = (RD_LATENCY != 0) ? ST_WAIT_RD : ST_SHIFT_IN;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_frame_nxt = {cmd_op, cmd_data};
          if (w_rd_blocked) begin
            w_reject    = 1'b1;
            w_state_nxt = ST_REJECT;
          end else begin
            w_state_nxt = (LEAD_CYCLES != 0) ? ST_LEAD : ST_SHIFT_OUT;
          end
        end
      end
      ST_LEAD:      if (w_last) w_state_nxt = ST_SHIFT_OUT;
      ST_SHIFT_OUT: if (w_last) w_state_nxt = w_after_out;
      ST_WAIT_RD:   if (w_last) w_state_nxt = ST_SHIFT_IN;
      ST_SHIFT_IN:  if (w_last) w_state_nxt = w_after_frame;
      ST_GAP:       if (w_last) w_state_nxt = ST_IDLE;
      ST_REJECT:    w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase

    // Each timed state counts from zero.
    if ((w_state_nxt != r_state) || (w_state_nxt == ST_IDLE)) begin
      w_cnt_nxt = '0;
    end

    w_frame_done = (w_state_nxt == ST_IDLE) && (r_state != ST_IDLE) && (r_state != ST_REJECT);
    w_ss_n_nxt   = !(w_state_nxt inside {ST_LEAD, ST_SHIFT_OUT, ST_WAIT_RD, ST_SHIFT_IN});
    w_bit_idx    = 4'(FRAME_W - 1) - 4'(w_cnt_nxt);
    w_mosi_nxt   = (w_state_nxt == ST_SHIFT_OUT) ? w_frame_nxt[w_bit_idx] : 1'b0;
    w_ready_nxt  = (w_state_nxt == ST_IDLE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Frame latch, MISO shift register and captured byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame    <= '0;
      r_sh       <= '0;
      r_rsp_data <= '0;
    end else begin
      r_frame <= w_frame_nxt;
      if (r_state == ST_SHIFT_IN) begin
        r_sh <= {r_sh[BYTE_W-3:0], MISO};
      end
      if (w_capture) begin
        r_rsp_data <= {r_sh, MISO};
      end
    end
  end

  // Registered interface outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_ss_n      <= w_ss_n_nxt;
      r_mosi      <= w_mosi_nxt;
      r_cmd_ready <= w_ready_nxt;
      r_busy      <= ~w_ready_nxt;
      r_done      <= w_frame_done | w_reject;
      r_rsp_valid <= w_capture | w_reject;
      r_rsp_err   <= w_reject;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign SS_n      = r_ss_n;
  assign MOSI      = r_mosi;
  assign done      = r_done;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized bench for spi_master with a cycle-timeline model of
// the frame rules and a behavioural RAM slave driving MISO.
`timescale 1ns/1ps
module tb_spi_master;

  localparam int unsigned LEAD = 1;
  localparam int unsigned RD   = 2;
  localparam int unsigned GAP  = 1;
  localparam int unsigned MAXT = 2048;
  localparam int B_SS   = 6;
  localparam int B_MOSI = 5;
  localparam int B_DONE = 4;
  localparam int B_RV   = 3;
  localparam int B_ERR  = 2;
  localparam int B_RDY  = 1;
  localparam int B_BUSY = 0;
`ifdef SPI_MASTER_RDADDR_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       done;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Slave / master model state
  logic [7:0] m_ram [256];
  logic [7:0] m_addr = 8'h00;
  logic       m_flag = 1'b0;
  logic [7:0] m_rdata = 8'h00;

  // Command queue for the next run
  logic [1:0]  q_op  [$];
  logic [7:0]  q_dat [$];
  int unsigned q_dly [$];

  // Planned per-cycle expectations and stimulus
  logic [6:0] e_ctl  [MAXT];
  logic [6:0] e_msk  [MAXT];
  logic [7:0] e_rd   [MAXT];
  logic       e_miso [MAXT];
  logic       d_vld  [MAXT];
  logic [1:0] d_op   [MAXT];
  logic [7:0] d_dat  [MAXT];

  spi_master #(
    .LEAD_CYCLES(LEAD),
    .RD_LATENCY (RD),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .done     (done),
    .busy     (busy),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return 32'({SS_n, MOSI, done, rsp_valid, rsp_err, cmd_ready, busy, rsp_data});
  endfunction

  // Reset values: SS_n=1, busy=1, everything else 0.
  function automatic logic [31:0] rst_vec();
    return 32'({7'b1000001, 8'h00});
  endfunction

  task automatic push(input logic [1:0] op, input logic [7:0] dat, input int unsigned dly);
    q_op.push_back(op);
    q_dat.push_back(dat);
    q_dly.push_back(dly);
  endtask

  // Plan the expected timeline of the queued commands, then drive and check it cycle by cycle.
  task automatic run(input string name);
    int unsigned r, a, prev_a, s, len, tend, t;
    logic [9:0]  fr;
    logic [7:0]  b;
    logic [6:0]  got;
    bit          rej;
    for (int i = 0; i < int'(MAXT); i++) begin
      e_ctl[i]  = 7'b1000010;
      e_msk[i]  = 7'h7f;
      e_rd[i]   = m_rdata;
      e_miso[i] = 1'($urandom);
      d_vld[i]  = 1'b0;
      d_op[i]   = 2'($urandom);
      d_dat[i]  = 8'($urandom);
    end
    r = 0;
    prev_a = 0;
    for (int k = 0; k < q_op.size(); k++) begin
      a = r + q_dly[k];
      s = (q_dly[k] == 0 && k > 0) ? prev_a + 1 : a;
      for (int i = int'(s); i <= int'(a); i++) begin
        d_vld[i] = 1'b1;
        d_op[i]  = q_op[k];
        d_dat[i] = q_dat[k];
      end
      fr  = {q_op[k], q_dat[k]};
      rej = CHK_EN && (q_op[k] == 2'b11) && !m_flag;
      if (rej) begin
        e_ctl[a+1][B_DONE] = 1'b1;
        e_ctl[a+1][B_RV]   = 1'b1;
        e_ctl[a+1][B_ERR]  = 1'b1;
        e_ctl[a+1][B_RDY]  = 1'b0;
        e_ctl[a+1][B_BUSY] = 1'b1;
        r = a + 2;
      end else begin
        len = LEAD + 10 + ((q_op[k] == 2'b11) ? RD + 8 : 0);
        b   = m_ram[m_addr];
        for (int unsigned c = 0; c < len; c++) begin
          t = a + 1 + c;
          e_ctl[t][B_SS]   = 1'b0;
          e_ctl[t][B_RDY]  = 1'b0;
          e_ctl[t][B_BUSY] = 1'b1;
          if (c >= LEAD && c < LEAD + 10) e_ctl[t][B_MOSI] = fr[9 - (c - LEAD)];
          if (c >= LEAD + 10 + RD) begin
            e_msk[t][B_MOSI] = 1'b0;
            e_miso[t] = b[7 - (c - LEAD - 10 - RD)];
          end
        end
        for (int unsigned g = 0; g < GAP; g++) begin
          e_ctl[a+1+len+g][B_RDY]  = 1'b0;
          e_ctl[a+1+len+g][B_BUSY] = 1'b1;
        end
        e_ctl[a+1+len+GAP][B_DONE] = 1'b1;
        case (q_op[k])
          2'b00: m_addr = q_dat[k];
          2'b01: m_ram[m_addr] = q_dat[k];
          2'b10: begin m_addr = q_dat[k]; m_flag = 1'b1; end
          default: begin
            e_ctl[a+1+len][B_RV] = 1'b1;
            for (int i = int'(a + 1 + len); i < int'(MAXT); i++) e_rd[i] = b;
            m_rdata = b;
          end
        endcase
        r = a + 1 + len + GAP;
      end
      prev_a = a;
    end
    tend = r + 3;
    for (int unsigned i = 0; i < tend; i++) begin
      @(negedge clk);
      got = {SS_n, MOSI, done, rsp_valid, rsp_err, cmd_ready, busy} & e_msk[i];
      check($sformatf("%s@%0d", name, i), 32'({got, rsp_data}), 32'({e_ctl[i] & e_msk[i], e_rd[i]}));
      cmd_valid = d_vld[i];
      cmd_op    = d_op[i];
      cmd_data  = d_dat[i];
      MISO      = e_miso[i];
    end
    q_op.delete();
    q_dat.delete();
    q_dly.delete();
  endtask

  // Reset in the middle of SHIFT_OUT bit 4 must drop the frame at once.
  task automatic abort_frame();
    @(negedge clk);
    check("abort_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_data  = 8'hFF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (LEAD + 4) @(negedge clk);
    check("abort_bit4", 32'({SS_n, MOSI, busy}), 32'b011);
    #1 rst_n = 1'b0;
    #1 check("abort_now", obs_vec(), rst_vec());
    repeat (2) begin
      @(negedge clk);
      check("abort_hold", obs_vec(), rst_vec());
    end
    rst_n   = 1'b1;
    m_flag  = 1'b0;
    m_rdata = 8'h00;
    @(negedge clk);
    check("abort_rdy", 32'({cmd_ready, busy}), 32'b10);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_ram[i] = 8'($urandom);
    repeat (2) @(negedge clk);
    check("rst_state", obs_vec(), rst_vec());
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rdy", 32'({cmd_ready, busy}), 32'b10);

    push(2'b00, 8'h5A, 0);
    run("wr5a");

    m_ram[8'h3C] = 8'hA7;
    push(2'b10, 8'h3C, 0);
    push(2'b11, 8'($urandom), 1);
    run("rd3c");

    push(2'b01, 8'h11, 0);
    push(2'b01, 8'h22, 0);
    push(2'b01, 8'h33, 0);
    run("b2b");

    abort_frame();

    m_ram[8'h55] = 8'h81;
    push(2'b11, 8'($urandom), 0);
    push(2'b00, 8'h12, 1);
    push(2'b10, 8'h55, 2);
    push(2'b11, 8'($urandom), 0);
    push(2'b11, 8'($urandom), 3);
    run("post_rst");

    for (int bt = 0; bt < 6; bt++) begin
      for (int k = 0; k < 8; k++) begin
        push(2'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(0, 3)));
      end
      run($sformatf("rnd%0d", bt));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
